// File: rtl/controle_multiciclo_pkg.sv
// controle_multiciclo_pkg: state encodings, ULA op codes, opcode and funct constants
package controle_multiciclo_pkg;
  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTE  = 4'd6,
    ALUWB    = 4'd7,
    BRANCH   = 4'd8,
    JUMP     = 4'd9,
    ERRO     = 4'd10
  } estado_t;
  localparam logic [3:0] ULA_AND = 4'b0000;
  localparam logic [3:0] ULA_OR  = 4'b0001;
  localparam logic [3:0] ULA_ADD = 4'b0010;
  localparam logic [3:0] ULA_SLL = 4'b0011;
  localparam logic [3:0] ULA_SRL = 4'b0100;
  localparam logic [3:0] ULA_SUB = 4'b0110;
  localparam logic [3:0] ULA_SLT = 4'b0111;
  localparam logic [3:0] ULA_NOR = 4'b1100;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] F_SLL = 6'h00;
  localparam logic [5:0] F_SRL = 6'h02;
  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_NOR = 6'h27;
  localparam logic [5:0] F_SLT = 6'h2A;
endpackage

// File: rtl/controle_multiciclo_ula_controle.sv
// ula_controle: decodes R-type funct into a ULA operation plus an invalid flag
module ula_controle
  import controle_multiciclo_pkg::*;
(
  input  logic [5:0] i_funct,
  output logic [3:0] o_ula_op,
  output logic       o_invalid
);
  // funct lookup; anything outside the table is flagged invalid
  always_comb begin
    o_ula_op  = ULA_AND;
    o_invalid = 1'b0;
    case (i_funct)
      F_ADD:   o_ula_op = ULA_ADD;
      F_SUB:   o_ula_op = ULA_SUB;
      F_AND:   o_ula_op = ULA_AND;
      F_OR:    o_ula_op = ULA_OR;
      F_NOR:   o_ula_op = ULA_NOR;
      F_SLT:   o_ula_op = ULA_SLT;
      F_SLL:   o_ula_op = ULA_SLL;
      F_SRL:   o_ula_op = ULA_SRL;
      default: o_invalid = 1'b1;
    endcase
  end
endmodule

// File: rtl/controle_multiciclo.sv
// controle_multiciclo: multicycle MIPS control FSM; define BNE_EN to accept bne (opcode 0x05)
module controle_multiciclo
  import controle_multiciclo_pkg::*;
#(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_source,
  output logic [3:0] ula_op,
  output logic [3:0] estado,
  output logic       excecao
);
  localparam int WW = $clog2(TIMEOUT_CYC + 2);
  estado_t       r_estado, w_next;
  logic [5:0]    r_funct;
  logic [WW-1:0] r_wait;
  logic [3:0]    w_ula_r;
  logic          w_funct_bad, w_wait, w_timeout, w_is_br, w_bz;
  ula_controle u_ula (.i_funct(r_funct), .o_ula_op(w_ula_r), .o_invalid(w_funct_bad));
  assign w_wait    = (r_estado == FETCH || r_estado == MEMREAD || r_estado == MEMWRITE) && !mem_ready;
  assign w_timeout = (TIMEOUT_CYC != 0) && w_wait && (r_wait == WW'(TIMEOUT_CYC - 1));
`ifdef BNE_EN
  logic r_bne;
  assign w_is_br = opcode == OP_BEQ || opcode == OP_BNE;
  assign w_bz    = r_bne ? ~zero : zero;
`else
  assign w_is_br = opcode == OP_BEQ;
  assign w_bz    = zero;
`endif
  assign estado  = r_estado;
  assign excecao = r_estado == ERRO;
  // next state; a memory timeout overrides whatever the state would do
  always_comb begin
    w_next = r_estado;
    case (r_estado)
      FETCH:    w_next = mem_ready ? DECODE : FETCH;
      DECODE:   w_next = (opcode == OP_LW || opcode == OP_SW) ? MEMADR :
                         opcode == OP_RTYPE ? EXECUTE :
                         w_is_br ? BRANCH :
                         opcode == OP_J ? JUMP : ERRO;
      MEMADR:   w_next = opcode == OP_LW ? MEMREAD : MEMWRITE;
      MEMREAD:  w_next = mem_ready ? MEMWB : MEMREAD;
      MEMWRITE: w_next = mem_ready ? FETCH : MEMWRITE;
      EXECUTE:  w_next = w_funct_bad ? ERRO : ALUWB;
      MEMWB, ALUWB, BRANCH, JUMP: w_next = FETCH;
      default:  w_next = ERRO;
    endcase
    if (w_timeout) w_next = ERRO;
  end
  // state, wait counter and funct/bne latches
  always_ff @(posedge clock) begin
    if (reset) begin
      r_estado <= FETCH;
      r_wait   <= '0;
      r_funct  <= '0;
    end else begin
      r_estado <= w_next;
      r_wait   <= (w_wait && w_next == r_estado) ? r_wait + 1'b1 : '0;
      if (r_estado == DECODE && w_next == EXECUTE) r_funct <= funct;
`ifdef BNE_EN
      if (r_estado == DECODE) r_bne <= opcode == OP_BNE;
`endif
    end
  end
  // control outputs decoded from the current state
  always_comb begin
    pc_write   = 1'b0;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    mem_to_reg = 1'b0;
    reg_dst    = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    pc_source  = 2'b00;
    ula_op     = ULA_AND;
    case (r_estado)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ula_op    = ULA_ADD;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      DECODE: begin
        alu_src_b = 2'b11;
        ula_op    = ULA_ADD;
      end
      MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        ula_op    = ULA_ADD;
      end
      MEMREAD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      MEMWRITE: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      EXECUTE: begin
        alu_src_a = 1'b1;
        ula_op    = w_ula_r;
      end
      ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        ula_op    = w_ula_r;
      end
      BRANCH: begin
        alu_src_a = 1'b1;
        ula_op    = ULA_SUB;
        pc_source = 2'b01;
        pc_write  = w_bz;
      end
      JUMP: begin
        pc_source = 2'b10;
        pc_write  = 1'b1;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_controle_multiciclo.sv
// tb_controle_multiciclo: table vectors, directed corner cases and random instruction streams
module tb_controle_multiciclo;
  localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMREAD = 4'd3,
                         S_MEMWB = 4'd4, S_MEMWRITE = 4'd5, S_EXECUTE = 4'd6, S_ALUWB = 4'd7,
                         S_BRANCH = 4'd8, S_JUMP = 4'd9, S_ERRO = 4'd10;
  logic clk = 1'b0, rst, zero, mem_ready;
  logic [5:0] opcode, funct;
  logic pc_write, i_or_d, mem_read, mem_write, ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, excecao;
  logic [1:0] alu_src_b, pc_source;
  logic [3:0] ula_op, estado;
  logic pw0, iod0, mr0, mw0, irw0, m2r0, rd0, rw0, asa0, exc0;
  logic [1:0] asb0, pcs0;
  logic [3:0] ula0, est0;
  logic [17:0] ctrl;
  int total = 0, bad = 0;
  logic [5:0] cur_fn;
  logic cur_bne;
  typedef struct { logic [3:0] st; logic mr; logic z; } step_t;
  step_t q[$];
  typedef struct { logic [5:0] op; logic [5:0] fn; logic z; int len; logic [3:0] last; logic [17:0] ctl; logic [3:0] fin; } vec_t;
  vec_t tv[$];
  logic [5:0] fl [8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h00, 6'h02};

  always #5 clk = ~clk;

  controle_multiciclo dut (
    .clock(clk), .reset(rst), .opcode(opcode), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .pc_source(pc_source), .ula_op(ula_op), .estado(estado), .excecao(excecao)
  );

  controle_multiciclo #(.TIMEOUT_CYC(0)) dut0 (
    .clock(clk), .reset(rst), .opcode(opcode), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pw0), .i_or_d(iod0), .mem_read(mr0), .mem_write(mw0), .ir_write(irw0),
    .mem_to_reg(m2r0), .reg_dst(rd0), .reg_write(rw0), .alu_src_a(asa0),
    .alu_src_b(asb0), .pc_source(pcs0), .ula_op(ula0), .estado(est0), .excecao(exc0)
  );

  assign ctrl = {pc_write, i_or_d, mem_read, mem_write, ir_write, mem_to_reg, reg_dst, reg_write,
                 alu_src_a, alu_src_b, pc_source, ula_op, excecao};

  // flags: pc_write i_or_d mem_read mem_write ir_write mem_to_reg reg_dst reg_write alu_src_a
  function automatic logic [17:0] k(input logic [8:0] f, input logic [1:0] asb, input logic [1:0] pcs,
                                    input logic [3:0] u, input logic e);
    return {f, asb, pcs, u, e};
  endfunction

  function automatic logic [4:0] ula_ref(input logic [5:0] f);
    case (f)
      6'h20: return {1'b1, 4'b0010};
      6'h22: return {1'b1, 4'b0110};
      6'h24: return {1'b1, 4'b0000};
      6'h25: return {1'b1, 4'b0001};
      6'h27: return {1'b1, 4'b1100};
      6'h2A: return {1'b1, 4'b0111};
      6'h00: return {1'b1, 4'b0011};
      6'h02: return {1'b1, 4'b0100};
      default: return 5'b0;
    endcase
  endfunction

  function automatic logic [17:0] exp_ctrl(input logic [3:0] st, input logic mr, input logic z,
                                           input logic bne, input logic [5:0] fn);
    logic [4:0] u;
    u = ula_ref(fn);
    case (st)
      S_FETCH:    return k({mr, 1'b0, 1'b1, 1'b0, mr, 4'b0000}, 2'b01, 2'b00, 4'b0010, 1'b0);
      S_DECODE:   return k(9'b000000000, 2'b11, 2'b00, 4'b0010, 1'b0);
      S_MEMADR:   return k(9'b000000001, 2'b10, 2'b00, 4'b0010, 1'b0);
      S_MEMREAD:  return k(9'b011000000, 2'b00, 2'b00, 4'b0000, 1'b0);
      S_MEMWB:    return k(9'b000001010, 2'b00, 2'b00, 4'b0000, 1'b0);
      S_MEMWRITE: return k(9'b010100000, 2'b00, 2'b00, 4'b0000, 1'b0);
      S_EXECUTE:  return k(9'b000000001, 2'b00, 2'b00, u[3:0], 1'b0);
      S_ALUWB:    return k(9'b000000110, 2'b00, 2'b00, u[3:0], 1'b0);
      S_BRANCH:   return k({bne ? ~z : z, 8'b00000001}, 2'b00, 2'b01, 4'b0110, 1'b0);
      S_JUMP:     return k(9'b100000000, 2'b00, 2'b10, 4'b0000, 1'b0);
      default:    return k(9'b000000000, 2'b00, 2'b00, 4'b0000, 1'b1);
    endcase
  endfunction

  task automatic chk(input string nm, input logic [17:0] act, input logic [17:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, want, $time);
    end
  endtask

  // leaves the bench just after a negedge with reset released and the DUT in FETCH
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    mem_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("rst_state", 18'(estado), 18'(S_FETCH));
    chk("rst_ctrl", ctrl, exp_ctrl(S_FETCH, 1'b1, zero, 1'b0, 6'h0));
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic push(input logic [3:0] st, input logic mr);
    q.push_back('{st, mr, 1'($urandom)});
  endtask

  // expected per-cycle trace of one instruction: kind 0 R ok, 1 R bad funct, 2 lw, 3 sw, 4 beq, 5 bne, 6 j, 7 bad op
  task automatic build(input int kind, input int fst, input int mst);
    logic [5:0] ops [8] = '{6'h00, 6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h3F};
    opcode = ops[kind];
    funct = kind == 0 ? fl[$urandom_range(0, 7)] : kind == 1 ? 6'h3F : 6'($urandom);
    cur_fn = funct;
    cur_bne = kind == 5;
    repeat (fst) push(S_FETCH, 1'b0);
    push(S_FETCH, 1'b1);
    push(S_DECODE, 1'($urandom));
    case (kind)
      0: begin push(S_EXECUTE, 1'($urandom)); push(S_ALUWB, 1'($urandom)); end
      1: begin push(S_EXECUTE, 1'($urandom)); push(S_ERRO, 1'b1); push(S_ERRO, 1'b0); end
      2: begin
        push(S_MEMADR, 1'($urandom));
        repeat (mst) push(S_MEMREAD, 1'b0);
        push(S_MEMREAD, 1'b1);
        push(S_MEMWB, 1'($urandom));
      end
      3: begin
        push(S_MEMADR, 1'($urandom));
        repeat (mst) push(S_MEMWRITE, 1'b0);
        push(S_MEMWRITE, 1'b1);
      end
      4: push(S_BRANCH, 1'($urandom));
`ifdef BNE_EN
      5: push(S_BRANCH, 1'($urandom));
`else
      5: begin push(S_ERRO, 1'b1); push(S_ERRO, 1'b0); end
`endif
      6: push(S_JUMP, 1'($urandom));
      default: begin push(S_ERRO, 1'b0); push(S_ERRO, 1'b1); push(S_ERRO, 1'b0); end
    endcase
  endtask

  task automatic run_q();
    logic [4:0] u;
    logic [17:0] m;
    u = ula_ref(cur_fn);
    for (int i = 0; i < q.size(); i++) begin
      mem_ready = q[i].mr;
      zero = q[i].z;
      m = (q[i].st == S_EXECUTE && !u[4]) ? 18'h3FFE1 : 18'h3FFFF;
      #1;
      chk("state", 18'(estado), 18'(q[i].st));
      chk("ctrl", ctrl & m, exp_ctrl(q[i].st, q[i].mr, q[i].z, cur_bne, cur_fn) & m);
      @(negedge clk);
    end
    if (q[q.size()-1].st == S_ERRO) do_reset();
    q.delete();
  endtask

  initial begin
    rst = 1'b1; mem_ready = 1'b0; zero = 1'b0; opcode = '0; funct = '0;
    do_reset();
    tv.push_back('{6'h00, 6'h20, 1'b0, 4, S_ALUWB, k(9'b000000110, 2'b00, 2'b00, 4'b0010, 1'b0), S_FETCH});
    tv.push_back('{6'h00, 6'h22, 1'b0, 4, S_ALUWB, k(9'b000000110, 2'b00, 2'b00, 4'b0110, 1'b0), S_FETCH});
    tv.push_back('{6'h00, 6'h24, 1'b1, 4, S_ALUWB, k(9'b000000110, 2'b00, 2'b00, 4'b0000, 1'b0), S_FETCH});
    tv.push_back('{6'h00, 6'h25, 1'b0, 4, S_ALUWB, k(9'b000000110, 2'b00, 2'b00, 4'b0001, 1'b0), S_FETCH});
    tv.push_back('{6'h00, 6'h27, 1'b0, 4, S_ALUWB, k(9'b000000110, 2'b00, 2'b00, 4'b1100, 1'b0), S_FETCH});
    tv.push_back('{6'h00, 6'h2A, 1'b0, 4, S_ALUWB, k(9'b000000110, 2'b00, 2'b00, 4'b0111, 1'b0), S_FETCH});
    tv.push_back('{6'h00, 6'h00, 1'b0, 4, S_ALUWB, k(9'b000000110, 2'b00, 2'b00, 4'b0011, 1'b0), S_FETCH});
    tv.push_back('{6'h00, 6'h02, 1'b0, 4, S_ALUWB, k(9'b000000110, 2'b00, 2'b00, 4'b0100, 1'b0), S_FETCH});
    tv.push_back('{6'h23, 6'h00, 1'b0, 5, S_MEMWB, k(9'b000001010, 2'b00, 2'b00, 4'b0000, 1'b0), S_FETCH});
    tv.push_back('{6'h2B, 6'h00, 1'b0, 4, S_MEMWRITE, k(9'b010100000, 2'b00, 2'b00, 4'b0000, 1'b0), S_FETCH});
    tv.push_back('{6'h04, 6'h00, 1'b1, 3, S_BRANCH, k(9'b100000001, 2'b00, 2'b01, 4'b0110, 1'b0), S_FETCH});
    tv.push_back('{6'h04, 6'h00, 1'b0, 3, S_BRANCH, k(9'b000000001, 2'b00, 2'b01, 4'b0110, 1'b0), S_FETCH});
    tv.push_back('{6'h02, 6'h00, 1'b0, 3, S_JUMP, k(9'b100000000, 2'b00, 2'b10, 4'b0000, 1'b0), S_FETCH});
    tv.push_back('{6'h3F, 6'h00, 1'b0, 2, S_DECODE, k(9'b000000000, 2'b11, 2'b00, 4'b0010, 1'b0), S_ERRO});
`ifdef BNE_EN
    tv.push_back('{6'h05, 6'h00, 1'b0, 3, S_BRANCH, k(9'b100000001, 2'b00, 2'b01, 4'b0110, 1'b0), S_FETCH});
    tv.push_back('{6'h05, 6'h00, 1'b1, 3, S_BRANCH, k(9'b000000001, 2'b00, 2'b01, 4'b0110, 1'b0), S_FETCH});
`else
    tv.push_back('{6'h05, 6'h00, 1'b0, 2, S_DECODE, k(9'b000000000, 2'b11, 2'b00, 4'b0010, 1'b0), S_ERRO});
`endif
    for (int i = 0; i < tv.size(); i++) begin
      do_reset();
      opcode = tv[i].op; funct = tv[i].fn; zero = tv[i].z; mem_ready = 1'b1;
      for (int c = 0; c <= tv[i].len; c++) begin
        #1;
        if (c == tv[i].len - 1) begin
          chk("vec_last", 18'(estado), 18'(tv[i].last));
          chk("vec_ctrl", ctrl, tv[i].ctl);
        end
        if (c == tv[i].len) chk("vec_end", 18'(estado), 18'(tv[i].fin));
        @(negedge clk);
      end
    end
    // lw stalled three cycles in MEMREAD
    do_reset();
    build(2, 0, 3);
    run_q();
    // bad opcode: ERRO must stay sticky until reset
    build(7, 1, 0);
    repeat (4) push(S_ERRO, 1'($urandom));
    run_q();
    // memory timeout in FETCH; the TIMEOUT_CYC=0 instance never gives up
    mem_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      #1;
      if (i == 15) chk("to_pre", 18'(estado), 18'(S_FETCH));
      @(negedge clk);
    end
    #1;
    chk("to_erro", 18'(estado), 18'(S_ERRO));
    chk("to_exc", 18'(excecao), 18'd1);
    repeat (24) @(negedge clk);
    #1;
    chk("to0_state", 18'(est0), 18'(S_FETCH));
    chk("to0_exc", 18'(exc0), 18'd0);
    // reset in the middle of a wait must clear the wait counter
    do_reset();
    mem_ready = 1'b0;
    repeat (10) @(negedge clk);
    do_reset();
    mem_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      #1;
      if (i == 15) chk("midwait_pre", 18'(estado), 18'(S_FETCH));
      @(negedge clk);
    end
    #1;
    chk("midwait_erro", 18'(estado), 18'(S_ERRO));
    do_reset();
    #1;
    chk("midwait_exc", 18'(excecao), 18'd0);
    @(negedge clk);
    do_reset();
    for (int n = 0; n < 80; n++) begin
      build($urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 4));
      run_q();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
